// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding, the default width and the half-subtractor primitive.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 8;

  // Returns {borrow, diff} of x - y.
  function automatic logic [1:0] half_sub(input logic x, input logic y);
    return {~x & y, x ^ y};
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The master side supplies operands and accepts results; the slave side is the subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int W = DEFAULT_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor_full_sub_cell.sv
// Combinational 1-bit full subtractor: x - y - bin.
// Two cascaded half-subtractors; either stage borrowing produces the outgoing borrow.
module full_sub_cell
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic [1:0] w_h1;
  logic [1:0] w_h2;

  assign w_h1 = half_sub(x, y);
  assign w_h2 = half_sub(w_h1[0], bin);
  assign d    = w_h2[0];
  assign bout = w_h1[1] | w_h2[1];
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Operands load in IDLE, W bits shift through one full-subtract cell in RUN, result is held in DONE.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus,
  output logic                 busy
);
  localparam int CW = $clog2(W + 1);

  state_t         r_state;
  logic [W-1:0]   r_a_sh;
  logic [W-1:0]   r_b_sh;
  logic [W-1:0]   r_diff;
  logic           r_bff;
  logic [CW-1:0]  r_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic           w_d;
  logic           w_bout;
  logic [W:0]     w_diff_ins;

  full_sub_cell u_cell (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_bff),
    .d    (w_d),
    .bout (w_bout)
  );

  // New bit enters at the MSB; the concatenation keeps this legal for W=1.
  assign w_diff_ins = {w_d, r_diff};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_diff      <= '0;
      r_bff       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh     <= bus.a;
            r_b_sh     <= bus.b;
            r_bff      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_diff <= w_diff_ins[W:1];
          r_bff  <= w_bout;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_bff;
  assign busy          = r_busy;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit unsigned subtractor computing A - B, one bit per clock, LSB first.
- Each bit is processed by a full-subtract cell built from two 1-bit half-subtractor cells, with the borrow held in a flip-flop between bits.
- Sits downstream of operand sources through a valid/ready input port.
- Feeds consumers through a valid/ready output port carrying the difference and the final borrow.

Parameters:
- W, 8, operand and difference width in bits; legal range W >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a, b present.
- in_ready  output  1  block can accept operands.
- a  input  W  minuend, unsigned.
- b  input  W  subtrahend, unsigned.
- out_valid  output  1  diff and borrow are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  W  (a - b) mod 2^W.
- borrow  output  1  1 when a < b (unsigned).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; diff=0; borrow=0; internal borrow flip-flop=0; bit counter=0; operand shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, load a and b into shift registers, clear the borrow flip-flop, set count=0, go to RUN.
  - in_ready=0 from the next cycle.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: take ai=a_sh[0], bi=b_sh[0], bin=borrow_ff.
  - Compute d=ai^bi^bin and bout=(~ai&bi) | (~(ai^bi)&bin).
  - Shift a_sh and b_sh right by 1.
  - Shift the diff register right, inserting d at bit W-1.
  - borrow_ff <= bout; count <= count+1.
  - On the edge where count==W-1 (the W-th bit), go to DONE.
  - Counter width is clog2(W+1) and it never wraps.
- DONE:
  - out_valid=1; diff and borrow=borrow_ff are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - diff and borrow keep their last values but are don't-care while out_valid=0.
- Latency: the operand handshake at edge T gives out_valid=1 after edge T+W.
- Throughput: one result per W+2 cycles minimum. in_ready=0 in DONE, so there is no bypass and a new operand is accepted only in IDLE.
- Input handshake: a and b are sampled only on the accepting edge. Changes to the inputs during RUN or DONE have no effect.
- Output handshake: out_valid never drops without an out_ready handshake, except on rst.
- in_valid while busy: ignored, with no side effects.
- Reset mid-operation: rst in RUN or DONE aborts immediately to the reset values and produces no partial out_valid.
- rst has priority over every handshake on the same edge.
- W=1: RUN lasts exactly one cycle. The result equals the 1-bit half-subtractor: diff=a^b, borrow=~a&b.
- Arithmetic: diff equals (a - b) mod 2^W; borrow equals (a < b). Wrap-around is the normal two's-complement result, for example 0-1 gives all ones with borrow=1.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the DEFAULT_W=8 constant.
- Sub-module full_sub_cell:
  - combinational; ports x, y, bin, d, bout;
  - built from two 1-bit half-subtractor cells plus an OR of their borrows;
  - instantiated once in the datapath.
- Top level holds the FSM, counter, shift registers and borrow flip-flop.

Test Plan:
- W=8, a=5, b=3, out_ready=1: in_ready drops after accept; out_valid rises exactly 8 cycles after the accept edge; diff=0x02, borrow=0; back in IDLE one cycle later.
- W=8, a=3, b=5: diff=0xFE, borrow=1. Then a=0x00, b=0x01: diff=0xFF, borrow=1. Then a=0xFF, b=0xFF: diff=0x00, borrow=0.
- Backpressure: a=0xA5, b=0x5A, out_ready=0 for 5 cycles after out_valid. diff=0x4B, borrow=0 held stable; in_valid pulses during this window are ignored; the result is released on the first out_ready=1.
- Reset mid-RUN: assert rst at bit 4 of a=0x80, b=0x01. Next cycle: all outputs at reset values, in_ready=1, no out_valid. A following a=0x10, b=0x01 gives diff=0x0F.
- W=1 instance: exhaustively apply (a,b)=00,01,10,11 and check (diff,borrow)=(0,0),(1,1),(1,0),(0,0), each result 1 cycle after its accept.
- Random regression, W=8, 1000 transactions with random in_valid/out_ready: scoreboard checks diff==(a-b)&0xFF and borrow==(a<b), and that no transaction is lost or duplicated.
